// File: rtl/nt_mon_pkg.sv
// Shared types and helpers for the Nt trigger monitor.
package nt_mon_pkg;

    // Monitor states, visible on the state output.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        TRIGGERED = 2'd2
    } state_t;

    // Counting modes selected by the COUNT_MODE parameter.
    localparam int CNT_CYCLES   = 0;
    localparam int CNT_CHANNELS = 1;

    // Saturating add for a counter of cw bits (cw <= 32).
    // The result sticks at 2^cw-1 instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned cw);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << cw) - 33'd1;
        if (sum > max_val) begin
            return max_val[31:0];
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/nt_delay_line.sv
// WIDTH-wide, DEPTH-stage enabled shift register. Stages hold when en=0.
module nt_delay_line
    import nt_mon_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per enabled edge; synchronous active-low clear of every stage.
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (en) begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/nt_trigger_monitor.sv
// Multi-channel Nt node monitor: delayed node evaluation, event counting and
// an arm/trigger state machine with a sticky alarm.
//
// There is no valid/ready handshake here: arm and clear are single-cycle
// pulses that act at the next edge, and clear wins over arm and over any
// count update in the same cycle.
module nt_trigger_monitor
    import nt_mon_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int DEPTH      = 2,
    parameter int CW         = 8,
    parameter int COUNT_MODE = 0
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             en,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] gate,
    input  logic             arm,
    input  logic             clear,
    input  logic [CW-1:0]    threshold,
    output logic [WIDTH-1:0] node_out,
    output logic             event_any,
    output logic [CW-1:0]    event_cnt,
    output logic             alarm,
    output logic [1:0]       state
);

    localparam int FW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] low;
    logic [FW-1:0]    fill_q;
    logic             valid;
    logic [CW-1:0]    pop;
    logic [CW-1:0]    inc;
    logic [CW-1:0]    cnt_sat;
    logic [CW-1:0]    eff_thr;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             alarm_q;
    state_t           state_q;
    state_t           state_d;

    nt_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_delay_a (
        .CLK  (CLK),
        .RSTB (RSTB),
        .en   (en),
        .din  (data_a),
        .dout (a_d)
    );

    nt_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_delay_b (
        .CLK  (CLK),
        .RSTB (RSTB),
        .en   (en),
        .din  (data_b),
        .dout (b_d)
    );

    // Node is low only when both delayed inputs are 0 and the gate is 1.
    assign node_out = a_d | b_d | ~gate;
    assign low      = ~node_out;

    // Count enabled cycles until the chains hold DEPTH fresh samples.
    // clear restarts the fill without flushing the chain contents.
    always_ff @(posedge CLK) begin
        if (!RSTB || clear) begin
            fill_q <= '0;
        end else if (en && !valid) begin
            fill_q <= fill_q + FW'(1);
        end
    end

    assign valid     = (fill_q == FW'(DEPTH));
    assign event_any = en & valid & (|low);

    // Per-cycle increment: one per event cycle, or the number of low channels.
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + CW'(low[i]);
        end
        if (COUNT_MODE == CNT_CHANNELS) begin
            inc = event_any ? pop : '0;
        end else begin
            inc = CW'(event_any);
        end
    end

    assign cnt_sat = CW'(sat_add(32'(cnt_q), 32'(inc), CW));
    assign eff_thr = (threshold == '0) ? CW'(1) : threshold;

    // Next-state and next-count logic; clear overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (arm) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    cnt_d = cnt_sat;
                    if ((inc != '0) && (cnt_sat >= eff_thr)) begin
                        state_d = TRIGGERED;
                    end
                end
                TRIGGERED: begin
                    cnt_d = cnt_sat;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and alarm registers; alarm trails the TRIGGERED state by one edge.
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alarm_q <= !clear && (state_q == TRIGGERED);
        end
    end

    assign event_cnt = cnt_q;
    assign alarm     = alarm_q;
    assign state     = state_q;

endmodule
